// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM traffic generator/checker.
//   - mode_e      : data pattern selection
//   - state_e     : sequencer states
//   - LFSR_TAPS   : Galois feedback mask for x^32 + x^22 + x^2 + x + 1
//   - lfsr_next   : one Galois LFSR step (right-shifting form)
//   - gen_pattern : data word for an address / LFSR state, PAT_MAX_W wide;
//                   callers truncate the result to their own data width.
package sdram_test_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,  // data = address
    MODE_NADDR = 2'd1,  // data = ~address
    MODE_LFSR  = 2'd2,  // data = LFSR state
    MODE_WALK1 = 2'd3   // data = 1 << (address mod data width)
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Taps 32,22,2,1 map to bits 31,21,1,0 in the right-shifting Galois form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Widest data word the pattern function can produce.
  localparam int PAT_MAX_W = 64;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

  function automatic logic [PAT_MAX_W-1:0] gen_pattern(
    input logic [1:0]           mode,
    input logic [PAT_MAX_W-1:0] addr,
    input logic [31:0]          lfsr,
    input int unsigned          data_w
  );
    logic [PAT_MAX_W-1:0] one;
    logic [PAT_MAX_W-1:0] w;
    one = PAT_MAX_W'(1);
    w   = PAT_MAX_W'(data_w);
    case (mode_e'(mode))
      MODE_ADDR:  return addr;
      MODE_NADDR: return ~addr;
      MODE_LFSR:  return PAT_MAX_W'(lfsr);
      default:    return one << (addr % w);
    endcase
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Pattern source shared by the write and read phases.
// Holds the 32-bit LFSR and produces the data word for the current address.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset (LFSR returns to seed)
//   reseed_i   reload LFSR with LFSR_SEED (has priority over step_i)
//   step_i     advance LFSR by one Galois step
//   mode_i     pattern mode (see mode_e)
//   addr_i     current address
//   pattern_o  combinational data word for addr_i / current LFSR state
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 24,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reseed_i,
  input  logic              step_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] pattern_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Address is zero-extended into the wide pattern and the result truncated,
  // so narrow/wide DATA_W versus ADDR_W both behave sensibly.
  assign pattern_o = DATA_W'(gen_pattern(mode_i, PAT_MAX_W'(addr_i), lfsr_q, DATA_W));

endmodule

// File: rtl/sdram_mem_tester.sv
// SDRAM traffic generator and checker driving the request side of an SDRAM
// controller. Each pass writes a pattern over [addr_first_i, addr_last_i],
// then reads the window back and compares against the regenerated pattern.
// Ports:
//   clock_50_i           system clock (rising edge)
//   rst_i                asynchronous active-high reset
//   start_i              one-cycle start pulse, honoured in IDLE/DONE only
//   mode_i               pattern mode, sampled on start
//   addr_first_i/last_i  inclusive address window, sampled on start
//   loop_en_i            keep repeating passes
//   stop_i               abort at the next request boundary
//   stop_on_err_i        finish on first miscompare
//   req_write_o/req_read_o, address_o, data_in_o  controller request side
//   data_out_i, data_valid_i, write_complete_i    controller response side
//   busy_o, done_o, pass_ok_o, timeout_o          status
//   err_count_o, first_err_addr_o, first_err_data_o, pass_count_o  results
module sdram_mem_tester
  import sdram_test_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 24,
  parameter int          ERR_W     = 16,
  parameter int          TIMEOUT   = 4096,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic              clock_50_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_first_i,
  input  logic [ADDR_W-1:0] addr_last_i,
  input  logic              loop_en_i,
  input  logic              stop_i,
  input  logic              stop_on_err_i,
  output logic              req_write_o,
  output logic              req_read_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_in_o,
  input  logic [DATA_W-1:0] data_out_i,
  input  logic              data_valid_i,
  input  logic              write_complete_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_ok_o,
  output logic              timeout_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic [15:0]       pass_count_o
);

  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [1:0]        mode_q, mode_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              to_q, to_d;
  logic              bad_q, bad_d;      // window was empty (last < first)
  logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0] ferr_data_q, ferr_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic              wc_prev_q, dv_prev_q;

  logic              wc_rise, dv_rise;
  logic              lfsr_reseed, lfsr_step;
  logic              at_last, mismatch, timer_expired;
  logic [DATA_W-1:0] pattern;

  sdram_pattern_gen #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern_gen (
    .clk_i     (clock_50_i),
    .rst_i     (rst_i),
    .reseed_i  (lfsr_reseed),
    .step_i    (lfsr_step),
    .mode_i    (mode_q),
    .addr_i    (addr_q),
    .pattern_o (pattern)
  );

  // A strobe held high counts once: only the 0->1 transition is an event.
  assign wc_rise       = write_complete_i & ~wc_prev_q;
  assign dv_rise       = data_valid_i & ~dv_prev_q;
  // Equality test before incrementing keeps a window ending at the top of
  // the address space from wrapping.
  assign at_last       = (addr_q == last_q);
  assign mismatch      = (rdata_q != pattern);
  assign timer_expired = (timer_q >= TMR_LAST);

  // State and datapath registers
  always_ff @(posedge clock_50_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      first_q     <= '0;
      last_q      <= '0;
      mode_q      <= '0;
      timer_q     <= '0;
      err_q       <= '0;
      to_q        <= 1'b0;
      bad_q       <= 1'b0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      rdata_q     <= '0;
      pass_cnt_q  <= '0;
      wc_prev_q   <= 1'b0;
      dv_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      to_q        <= to_d;
      bad_q       <= bad_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      rdata_q     <= rdata_d;
      pass_cnt_q  <= pass_cnt_d;
      wc_prev_q   <= write_complete_i;
      dv_prev_q   <= data_valid_i;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    first_d     = first_q;
    last_d      = last_q;
    mode_d      = mode_q;
    timer_d     = timer_q;
    err_d       = err_q;
    to_d        = to_q;
    bad_d       = bad_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    rdata_d     = rdata_q;
    pass_cnt_d  = pass_cnt_q;
    lfsr_reseed = 1'b0;
    lfsr_step   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          first_d     = addr_first_i;
          last_d      = addr_last_i;
          addr_d      = addr_first_i;
          mode_d      = mode_i;
          err_d       = '0;
          to_d        = 1'b0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          pass_cnt_d  = '0;
          lfsr_reseed = 1'b1;
          bad_d       = (addr_last_i < addr_first_i);
          state_d     = (addr_last_i < addr_first_i) ? ST_DONE : ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        timer_d = '0;
        state_d = stop_i ? ST_DONE : ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (wc_rise) begin
          if (at_last) begin
            addr_d      = first_q;
            lfsr_reseed = 1'b1;
            state_d     = ST_RD_REQ;
          end else begin
            addr_d    = addr_q + ADDR_W'(1);
            lfsr_step = 1'b1;
            state_d   = ST_WR_REQ;
          end
        end else if (timer_expired) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_RD_REQ: begin
        timer_d = '0;
        state_d = stop_i ? ST_DONE : ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (dv_rise) begin
          rdata_d = data_out_i;
          state_d = ST_CHECK;
        end else if (timer_expired) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          // The counter saturates and never returns to zero, so zero
          // identifies the first miscompare of the run.
          if (err_q == '0) begin
            ferr_addr_d = addr_q;
            ferr_data_d = rdata_q;
          end
        end
        if (mismatch && stop_on_err_i) begin
          state_d = ST_DONE;
        end else if (at_last) begin
          pass_cnt_d  = pass_cnt_q + 16'd1;
          addr_d      = first_q;
          lfsr_reseed = 1'b1;
          state_d     = (loop_en_i && !stop_i) ? ST_WR_REQ : ST_DONE;
        end else begin
          addr_d    = addr_q + ADDR_W'(1);
          lfsr_step = 1'b1;
          state_d   = ST_RD_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. Requests decode straight from the state register so an
  // asynchronous reset drops them at once; stop_i suppresses the request
  // in the same cycle the sequencer decides to abort.
  always_comb begin
    req_write_o = 1'b0;
    req_read_o  = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE:   busy_o = 1'b0;
      ST_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      ST_WR_REQ: req_write_o = ~stop_i;
      ST_RD_REQ: req_read_o  = ~stop_i;
      default:   ;
    endcase
    pass_ok_o = done_o && (err_q == '0) && !to_q && !bad_q;
  end

  assign address_o        = addr_q;
  assign data_in_o        = pattern;
  assign timeout_o        = to_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;
  assign pass_count_o     = pass_cnt_q;

endmodule

// File: tb/tb_sdram_mem_tester.sv
module tb_sdram_mem_tester;

  localparam int          DW   = 32;
  localparam int          AW   = 24;
  localparam int          EW   = 16;
  localparam int          TO   = 64;
  localparam int          LAT  = 2;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] a_first = '0;
  logic [AW-1:0] a_last = '0;
  logic          loop_en = 1'b0;
  logic          stop = 1'b0;
  logic          soe = 1'b0;
  logic          req_write, req_read;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid, write_complete;
  logic          busy, done, pass_ok, timeout;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic [15:0]   pass_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_req_cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_mem_tester #(
    .DATA_W(DW), .ADDR_W(AW), .ERR_W(EW), .TIMEOUT(TO), .LFSR_SEED(SEED)
  ) dut (
    .clock_50_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .addr_first_i(a_first), .addr_last_i(a_last), .loop_en_i(loop_en),
    .stop_i(stop), .stop_on_err_i(soe), .req_write_o(req_write),
    .req_read_o(req_read), .address_o(address), .data_in_o(data_in),
    .data_out_i(data_out), .data_valid_i(data_valid),
    .write_complete_i(write_complete), .busy_o(busy), .done_o(done),
    .pass_ok_o(pass_ok), .timeout_o(timeout), .err_count_o(err_count),
    .first_err_addr_o(first_err_addr), .first_err_data_o(first_err_data),
    .pass_count_o(pass_count)
  );

  // ---------------- controller model ----------------
  logic [31:0]   mem [0:1023];
  int            wc_cnt, dv_cnt;
  logic [AW-1:0] rd_addr;
  bit            no_wc = 1'b0;
  logic [AW-1:0] cor_addr0 = '0, cor_addr1 = '0;
  logic [31:0]   cor_mask0 = '0, cor_mask1 = '0;

  function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = mem[a[9:0]];
    if (a == cor_addr0) w = w ^ cor_mask0;
    if (a == cor_addr1) w = w ^ cor_mask1;
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      write_complete <= 1'b0;
      data_valid     <= 1'b0;
      data_out       <= '0;
      wc_cnt         <= 0;
      dv_cnt         <= 0;
      rd_addr        <= '0;
    end else begin
      write_complete <= 1'b0;
      data_valid     <= 1'b0;
      if (req_write) begin
        mem[address[9:0]] <= data_in;
        wc_cnt <= LAT;
      end else if (wc_cnt > 0) begin
        wc_cnt <= wc_cnt - 1;
        if (wc_cnt == 1 && !no_wc) write_complete <= 1'b1;
      end
      if (req_read) begin
        rd_addr <= address;
        dv_cnt  <= LAT;
      end else if (dv_cnt > 0) begin
        dv_cnt <= dv_cnt - 1;
        if (dv_cnt == 1) begin
          data_valid <= 1'b1;
          data_out   <= rd_word(rd_addr);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } req_t;

  typedef struct {
    bit            ok;
    bit            to;
    logic [31:0]   err;
    logic [AW-1:0] fea;
    logic [31:0]   fed;
    logic [31:0]   pc;
  } res_t;

  req_t exp_req[$];
  res_t exp_res[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] pat(input logic [1:0] m, input logic [AW-1:0] a,
                                      input logic [31:0] s);
    case (m)
      2'd0:    return 32'(a);
      2'd1:    return ~32'(a);
      default: return s;
    endcase
  endfunction

  task automatic push_req(input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
    req_t r;
    r.is_wr = wr; r.addr = a; r.data = d;
    exp_req.push_back(r);
  endtask

  task automatic push_res(input bit ok, input bit to, input logic [31:0] err,
                          input logic [AW-1:0] fea, input logic [31:0] fed,
                          input logic [31:0] pc);
    res_t r;
    r.ok = ok; r.to = to; r.err = err; r.fea = fea; r.fed = fed; r.pc = pc;
    exp_res.push_back(r);
  endtask

  // Full write phase over [f,l], then reads of the first nrd addresses.
  task automatic push_pass(input logic [1:0] m, input logic [AW-1:0] f,
                           input logic [AW-1:0] l, input int nrd);
    logic [31:0] s;
    int n;
    n = int'(l) - int'(f) + 1;
    s = SEED;
    for (int i = 0; i < n; i++) begin
      push_req(1'b1, f + AW'(i), pat(m, f + AW'(i), s));
      s = lfsr_step(s);
    end
    for (int i = 0; i < nrd; i++) push_req(1'b0, f + AW'(i), '0);
  endtask

  // Monitor: pops expected requests/results whenever the DUT presents them.
  bit   prev_rw = 1'b0, prev_rd = 1'b0, prev_done = 1'b0;
  req_t mon_e;
  res_t mon_r;

  always @(negedge clk) begin
    if (req_write || req_read) begin
      last_req_cyc = cyc;
      check("req_pulse_width", {31'b0, (req_write && prev_rw) || (req_read && prev_rd)}, 32'd0);
      check("req_exclusive", {31'b0, req_write && req_read}, 32'd0);
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req act=wr%0b/rd%0b@%h exp=none", req_write, req_read, address);
      end else begin
        mon_e = exp_req.pop_front();
        $display("req %s addr=%h data=%h", req_write ? "WR" : "RD", address, data_in);
        check("req_kind", {31'b0, req_write}, {31'b0, mon_e.is_wr});
        check("req_addr", 32'(address), 32'(mon_e.addr));
        if (mon_e.is_wr) check("req_data", data_in, mon_e.data);
      end
    end
    if (done && !prev_done) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0");
      end else begin
        mon_r = exp_res.pop_front();
        $display("done pass_ok=%0b timeout=%0b err=%0d fea=%h fed=%h passes=%0d",
                 pass_ok, timeout, err_count, first_err_addr, first_err_data, pass_count);
        check("pass_ok", {31'b0, pass_ok}, {31'b0, mon_r.ok});
        check("timeout", {31'b0, timeout}, {31'b0, mon_r.to});
        check("err_count", 32'(err_count), mon_r.err);
        check("first_err_addr", 32'(first_err_addr), 32'(mon_r.fea));
        check("first_err_data", first_err_data, mon_r.fed);
        check("pass_count", 32'(pass_count), mon_r.pc);
      end
    end
    prev_rw   = req_write;
    prev_rd   = req_read;
    prev_done = done;
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [1:0] m, input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk); #1;
    mode = m; a_first = f; a_last = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_done_reached"}, {31'b0, done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_req_left"}, 32'(exp_req.size()), 32'd0);
    check({nm, "_res_left"}, 32'(exp_res.size()), 32'd0);
    exp_req.delete();
    exp_res.delete();
  endtask

  initial begin : stim
    logic [31:0] s;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_write", {31'b0, req_write}, 32'd0);
    check("rst_req_read", {31'b0, req_read}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass_ok", {31'b0, pass_ok}, 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_pass_count", 32'(pass_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Mode 0, window 0..15
    push_pass(2'd0, 24'h0, 24'hF, 16);
    push_res(1'b1, 1'b0, 0, '0, '0, 1);
    do_start(2'd0, 24'h0, 24'hF);
    wait_done(2000, "mode0");

    // Mode 2 LFSR, 0x100..0x13F, clean
    push_pass(2'd2, 24'h100, 24'h13F, 64);
    push_res(1'b1, 1'b0, 0, '0, '0, 1);
    do_start(2'd2, 24'h100, 24'h13F);
    wait_done(4000, "mode2");

    // Mode 2 with bit 5 flipped on readback of 0x120
    s = SEED;
    for (int i = 0; i < 32; i++) s = lfsr_step(s);
    cor_addr0 = 24'h120; cor_mask0 = 32'h20;
    push_pass(2'd2, 24'h100, 24'h13F, 64);
    push_res(1'b0, 1'b0, 1, 24'h120, s ^ 32'h20, 1);
    do_start(2'd2, 24'h100, 24'h13F);
    wait_done(4000, "mode2_corrupt");
    cor_mask0 = '0;

    // Mode 1, stop_on_err, corruption at 3 and 7 -> stops after address 3
    soe = 1'b1;
    cor_addr0 = 24'h3; cor_mask0 = 32'h1;
    cor_addr1 = 24'h7; cor_mask1 = 32'h1;
    push_pass(2'd1, 24'h0, 24'hF, 4);
    push_res(1'b0, 1'b0, 1, 24'h3, 32'hFFFF_FFFD, 0);
    do_start(2'd1, 24'h0, 24'hF);
    wait_done(2000, "mode1_soe");
    soe = 1'b0; cor_mask0 = '0; cor_mask1 = '0;

    // Mode 3 walking one across the DATA_W boundary
    push_req(1'b1, 24'h1E, 32'h4000_0000);
    push_req(1'b1, 24'h1F, 32'h8000_0000);
    push_req(1'b1, 24'h20, 32'h0000_0001);
    push_req(1'b1, 24'h21, 32'h0000_0002);
    for (int i = 0; i < 4; i++) push_req(1'b0, 24'h1E + AW'(i), '0);
    push_res(1'b1, 1'b0, 0, '0, '0, 1);
    do_start(2'd3, 24'h1E, 24'h21);
    wait_done(1000, "mode3");

    // Window ending at the top of the address space
    push_pass(2'd0, 24'hFFFFFE, 24'hFFFFFF, 2);
    push_res(1'b1, 1'b0, 0, '0, '0, 1);
    do_start(2'd0, 24'hFFFFFE, 24'hFFFFFF);
    wait_done(500, "top_window");

    // Timeout: write_complete never arrives
    no_wc = 1'b1;
    push_req(1'b1, 24'h0, 32'h0);
    push_res(1'b0, 1'b1, 0, '0, '0, 0);
    do_start(2'd0, 24'h0, 24'h3);
    n = 0;
    while (!timeout && n < 4 * TO) begin
      @(posedge clk); #1;
      n++;
    end
    // Request cycle plus TO full wait cycles, then the flag registers.
    check("timeout_latency", 32'(cyc - last_req_cyc), 32'(TO + 1));
    wait_done(10, "timeout");
    repeat (20) @(posedge clk);
    no_wc = 1'b0;

    // Looping, stop at the start of the 4th pass
    loop_en = 1'b1;
    for (int p = 0; p < 3; p++) push_pass(2'd0, 24'h0, 24'h3, 4);
    push_res(1'b1, 1'b0, 0, '0, '0, 3);
    do_start(2'd0, 24'h0, 24'h3);
    n = 0;
    while (pass_count != 16'd3 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("loop_pass3_reached", 32'(pass_count), 32'd3);
    stop = 1'b1;
    wait_done(TO, "loop_stop");
    stop = 1'b0; loop_en = 1'b0;

    // Asynchronous reset while in RD_WAIT
    push_pass(2'd0, 24'h0, 24'hF, 1);
    do_start(2'd0, 24'h0, 24'hF);
    n = 0;
    while (!req_read && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rdwait_reached", {31'b0, req_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_req_read", {31'b0, req_read}, 32'd0);
    check("async_rst_req_write", {31'b0, req_write}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("async_rst_req_left", 32'(exp_req.size()), 32'd0);
    exp_req.delete();

    // Empty window after reset
    push_res(1'b0, 1'b0, 0, '0, '0, 0);
    do_start(2'd0, 24'h5, 24'h2);
    wait_done(20, "bad_window");
    check("bad_window_done", {31'b0, done}, 32'd1);
    check("bad_window_pass_ok", {31'b0, pass_ok}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
